// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART frame definitions used by both the transmitter and the receiver,
// so both ends agree on the frame layout:
//   1 start bit (0), 7 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
// Contents: frame size constants, FSM state encoding, even-parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 7;
    localparam int UART_FRAME_BITS = 10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Valid/ready word handshake into the UART transmitter.
//   tx_data  : word to send (sampled on acceptance)
//   tx_valid : producer has a word on tx_data
//   tx_ready : transmitter can accept a word
// Modports: master (word producer), slave (transmitter).
// -----------------------------------------------------------------------------
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period divider. Counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle bit_done pulse on the last cycle of each bit. The count is held
// at zero whenever enable is low, so every enabled stretch starts a fresh bit.
// Ports:
//   clk      : system clock (rising edge)
//   rst      : asynchronous active-low reset
//   enable   : run the divider
//   bit_done : high on the final cycle of the current bit
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_done = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter: start(0), 7 data bits LSB first, even parity,
// stop(1). Each bit is held for CLKS_PER_BIT clocks.
// Ports:
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-low reset
//   up   : word handshake (uart_tx_if.slave); tx_ready high only in IDLE
//   tx   : registered serial line, idles high
//   busy : a frame is in flight (state other than IDLE)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   up,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [2:0]                state_q,   state_d;
    logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
    logic                      par_q,     par_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      tx_q,      tx_d;
    logic                      bit_done;
    logic                      accept;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .enable   (state_q != ST_IDLE),
        .bit_done (bit_done)
    );

    assign accept = up.tx_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = up.tx_data;
                    par_d     = even_parity(up.tx_data);
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line level is computed from the next state so the registered tx
    // changes on the same edge as the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign up.tx_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx          = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx with CLKS_PER_BIT = 4. Stimulus pushes the
// expected word and hand-computed parity into a queue; a line monitor decodes
// each frame from tx and compares it against the queue head.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;

    typedef struct packed {
        logic [6:0] d;
        logic       p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    logic busy;

    uart_tx_if bus();

    uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .up   (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_evts = 0;
    always @(negedge rst) rst_evts <= rst_evts + 1;

    int   tests  = 0;
    int   fails  = 0;
    int   frames = 0;
    exp_t exp_q[$];
    int   start_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Line monitor: detect start at a falling edge sample, then sample every
    // bit in its middle (offset 2 of 4). Frames cut by a reset are discarded.
    initial begin : monitor
        logic [9:0] fr;
        int         sc;
        int         r0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                sc = cyc;
                r0 = rst_evts;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? 2 : 4) @(negedge clk);
                    fr[k] = tx;
                end
                if (rst_evts == r0) begin
                    frames++;
                    start_q.push_back(sc);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got frame %b expected none", fr);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", 32'(fr), 32'({1'b1, e.p, e.d, 1'b0}));
                    end
                end
            end
        end
    end

    // Offer a word, wait for tx_ready, record the expectation, and return at
    // the first negedge after the accepting edge.
    task automatic send(input logic [6:0] d, input logic p, input bit hold);
        int n;
        n = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got tx_ready %b expected 1", bus.tx_ready);
        end
        exp_q.push_back('{d: d, p: p});
        @(negedge clk);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy %b expected 0", busy);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int bad;
        int idle;
        int f0;
        int sz;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_20", 32'(bad), 32'd0);

        // Single word 0x55 (four ones -> parity 0)
        send(7'h55, 1'b0, 1'b0);
        check("start_low", 32'(tx), 32'd0);
        check("ready_low", 32'(bus.tx_ready), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", 32'(n), 32'd40);
        check("post_tx", 32'(tx), 32'd1);
        check("post_ready", 32'(bus.tx_ready), 32'd1);
        wait_idle();

        // Parity cases
        send(7'h7F, 1'b1, 1'b0);
        wait_idle();
        send(7'h00, 1'b0, 1'b0);
        wait_idle();
        send(7'h01, 1'b1, 1'b0);
        wait_idle();

        // Back-to-back with tx_valid held: 0x12 (parity 0), 0x6B (parity 1)
        send(7'h12, 1'b0, 1'b1);
        bus.tx_data = 7'h6B;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp_q.push_back('{d: 7'h6B, p: 1'b1});
        idle = 0;
        while (busy === 1'b0 && idle < 10) begin
            idle++;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("b2b_idle", 32'(idle), 32'd1);
        wait_idle();
        sz = start_q.size();
        if (sz >= 2) begin
            check("b2b_gap", 32'(start_q[sz-1] - start_q[sz-2]), 32'd41);
        end else begin
            tests++;
            fails++;
            $display("FAIL b2b_gap: got %0d frames expected 2 or more", sz);
        end

        // Busy ignore: 0x2A (parity 1), pulse 0x15 mid-frame
        f0 = frames;
        send(7'h2A, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        bus.tx_data  = 7'h15;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_idle();
        repeat (60) @(negedge clk);
        check("ignore_frames", 32'(frames - f0), 32'd1);

        // Reset during DATA bit 3 of 0x33 (bit 3 is 0)
        send(7'h33, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        check("pre_rst_tx", 32'(tx), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        check("rst_async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_ready", 32'(bus.tx_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_tx", 32'(tx), 32'd1);
        repeat (50) @(negedge clk);

        // Clean frame after reset: 0x0F (parity 0)
        send(7'h0F, 1'b0, 1'b0);
        wait_idle();

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(frames), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the 10-bit frame used by the receive path: 1 start bit (0), 7 data bits LSB first, 1 even-parity bit, 1 stop bit (1). It sits directly upstream of the UART receiver, so its serial output drives the receiver's serial input. A valid/ready handshake accepts one 7-bit word at a time, and an internal divider holds each bit for a fixed number of clock cycles.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range ≥ 2.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk).
- tx_data  input  7  word to send; sampled only on acceptance.
- tx_valid  input  1  upstream has a word on tx_data.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight (any state other than IDLE).

## Operation
- Reset (rst = 0) sets: state IDLE, tx = 1, tx_ready = 1, busy = 0, bit counter = 0, cycle counter = 0, shift register = 0.
- A word is accepted on a rising edge where tx_valid and tx_ready are both high. On acceptance:
  - tx_data is latched into the shift register.
  - The parity bit is latched as the XOR of all 7 bits, so the count of ones in data plus parity is even.
- State machine:
  - IDLE: tx = 1. On acceptance, go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit counter. After the 7th bit (counter = 6 at bit end), go to PARITY.
  - PARITY: tx = latched parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Once accepted, a word is fixed. Changes on tx_data or tx_valid during a frame have no effect.
- tx_valid while busy is ignored; it is not queued.
- tx is driven from a register, so no glitches reach the line.
- Cycle counter: counts 0 to CLKS_PER_BIT−1 and wraps at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Bit counter: 3 bits wide, range 0 to 6.
- Reset mid-frame: the frame is aborted and tx returns to 1 immediately, without waiting for a clock. No partial word is resumed after reset.

## Timing
- Acceptance at edge N:
  - tx falls to 0 and busy rises after edge N.
  - tx_ready falls after edge N.
- Each bit lasts exactly CLKS_PER_BIT cycles. A whole frame occupies tx for 10 × CLKS_PER_BIT cycles.
- After the last STOP cycle the block is in IDLE for at least one cycle, with tx_ready = 1 and tx = 1.
- With tx_valid held high, back-to-back frames repeat every 10 × CLKS_PER_BIT + 1 cycles.
- Latency from acceptance to the first data bit on tx: CLKS_PER_BIT + 1 edges.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_BITS = 7 and UART_FRAME_BITS = 10.
  - The state encoding: IDLE, START, DATA, PARITY, STOP.
  - An even-parity function.
- The receiver consumes the same package constants, so both ends agree on the frame format.
- The divider is a natural sub-module, uart_baud_gen:
  - Parameter CLKS_PER_BIT; inputs clk, rst, enable.
  - Outputs a 1-cycle bit_done pulse on the last cycle of each bit.
  - The counter restarts when enable is low, so it is reusable by the receiver.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset then idle: hold rst = 0, then release it. Expect tx = 1, tx_ready = 1 and busy = 0 for 20 cycles with tx_valid = 0.
- Single word 7'h55:
  - Expect the line sequence 0, 1,0,1,0,1,0,1, parity 0, stop 1, each bit lasting 4 cycles.
  - Expect busy high for exactly 40 cycles.
  - A loopback to the receiver yields a correct frame.
- Parity cases:
  - 7'h7F gives parity bit 1.
  - 7'h00 gives parity bit 0.
  - 7'h01 gives parity bit 1.
- Back-to-back: hold tx_valid high and send 7'h12 then 7'h6B.
  - Start bits are 41 cycles apart.
  - Exactly one idle-high cycle separates the frames.
  - Both words decode correctly.
- Busy ignore: during a frame of 7'h2A, pulse tx_valid with tx_data = 7'h15. Expect the line to carry only 7'h2A, with no second frame.
- Reset mid-frame: assert rst during DATA bit 3 of 7'h33.
  - tx goes to 1 asynchronously in the same cycle.
  - After release, the state is IDLE.
  - A subsequent 7'h0F transmits cleanly.
